fir_out_buf: RTL and testbench
==============================

FIR_OUT_BUF -- requirements
Module: fir_out_buf

Interface
REQ-001 Parameter WIDTH, default 11, sample width in bits (matches FIR DOUT).
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 DIN  input  WIDTH  signed sample from the FIR DOUT.
REQ-006 VIN  input  1  DIN valid, from the FIR VOUT; no backpressure to the FIR.
REQ-007 READY  input  1  downstream consumer accepts the current DOUT.
REQ-008 DOUT  output  WIDTH  signed sample at FIFO head.
REQ-009 VOUT  output  1  DOUT valid (FIFO not empty).
REQ-010 LEVEL  output  log2(DEPTH)+1  current number of stored samples, 0..DEPTH.
REQ-011 OVF  output  1  overflow indication; a sample was dropped.

Function
REQ-012 Circular buffer: DEPTH x WIDTH storage, write pointer, read pointer, occupancy counter; pointers wrap from DEPTH-1 to 0.
REQ-013 Push: on an edge with VIN=1 and the buffer not full, DIN is stored at the write pointer and the write pointer advances.
REQ-014 Pop: on an edge with VOUT=1 and READY=1, the read pointer advances.
REQ-015 VOUT = (LEVEL != 0); DOUT = storage[read pointer] when VOUT=1, all-zero when VOUT=0.
REQ-016 Latency: a sample pushed at edge N is visible on DOUT/VOUT after edge N (first-word fall-through, 1 cycle).
REQ-017 Simultaneous push and pop, buffer neither full nor empty: both occur; LEVEL unchanged.
REQ-018 Simultaneous VIN=1 and pop while full: push accepted (pop frees the slot); LEVEL stays DEPTH; no overflow.
REQ-019 VIN=1 while full and no pop: DIN dropped, storage/pointers unchanged, overflow event raised.
REQ-020 VIN=1 while empty: push only (pop impossible since VOUT=0); READY ignored while VOUT=0.
REQ-021 LEVEL: +1 on push-only, -1 on pop-only, unchanged otherwise; never exceeds DEPTH or goes below 0.
REQ-022 DOUT and DIN treated as signed two's complement; no arithmetic or width change on the data path.

Reset
REQ-023 RST=1 immediately (asynchronously) clears both pointers, LEVEL=0, VOUT=0, DOUT=0, OVF=0.
REQ-024 Storage contents are not reset; they are never observable while empty.
REQ-025 Reset asserted mid-operation discards all stored samples; the first VIN=1 edge after RST deasserts is a normal push.
REQ-026 VIN and READY are ignored while RST=1.

Configuration
REQ-027 Macro FIR_OUT_BUF_OVF_STICKY_EN selects overflow reporting mode.
REQ-028 Defined: OVF set at the first overflow event and held at 1 until RST.
REQ-029 Undefined: OVF is a registered one-cycle pulse, high for exactly the cycle following each overflow edge.
REQ-030 In both modes data behaviour (REQ-012..REQ-022) is identical.

Verification
REQ-031 Reset then VIN=1 for one cycle with DIN=0x123, READY=0 -> next cycle VOUT=1, DOUT=0x123, LEVEL=1.
REQ-032 READY=0, push 8 samples 1..8, then a 9th (DIN=9) -> LEVEL=8, sample 9 dropped, OVF=1; then READY=1 -> DOUT reads 1..8 in order, VOUT=0 after 8 pops.
REQ-033 Full buffer, VIN=1 DIN=0x7FF with READY=1 same edge -> LEVEL stays 8, OVF=0, 0x7FF emerges last of the 8.
REQ-034 Continuous VIN=1 and READY=1 with ramp DIN=-5..+5 (0x7FB..0x005) -> LEVEL toggles 0/1 only, DOUT replays ramp 1 cycle delayed, no drops.
REQ-035 Overflow then 3 more cycles -> OVF held 1 with FIR_OUT_BUF_OVF_STICKY_EN, 1 for one cycle only without it.
REQ-036 LEVEL=5 and RST pulsed mid-cycle -> VOUT=0, LEVEL=0, DOUT=0 before the next edge; subsequent push of 0x055 appears as first DOUT.

Source files
------------

// File: rtl/fir_out_buf_if.sv
// Sample/handshake bundle between the FIR output buffer, the FIR and the downstream consumer.
interface fir_out_buf_if #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    // Data is two's complement; the buffer never does arithmetic on it.
    logic [WIDTH-1:0] din;
    logic             vin;
    logic             ready;
    logic [WIDTH-1:0] dout;
    logic             vout;
    logic [LW-1:0]    level;
    logic             ovf;

    modport slave  (input din, vin, ready, output dout, vout, level, ovf);
    modport master (output din, vin, ready, input dout, vout, level, ovf);
endinterface

// File: rtl/fir_out_buf.sv
// First-word fall-through circular buffer behind the FIR output; overflow drops the new sample.
// Define FIR_OUT_BUF_OVF_STICKY_EN for a sticky ovf flag; default is a one-cycle ovf pulse.
module fir_out_buf #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    fir_out_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             ovf_q;

    logic empty;
    logic full;
    logic pop;
    logic push;
    logic ovf_event;

    assign empty     = (count == '0);
    assign full      = (count == LW'(DEPTH));
    assign pop       = !empty && bus.ready;
    // A pop on the same edge frees the slot, so a full buffer can still accept.
    assign push      = bus.vin && (!full || pop);
    assign ovf_event = bus.vin && full && !pop;

    // NOTE: storage has no reset; it is only ever read through rd_ptr while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
`ifdef FIR_OUT_BUF_OVF_STICKY_EN
            if (ovf_event) begin
                ovf_q <= 1'b1;
            end
`else
            ovf_q <= ovf_event;
`endif
        end
    end

    assign bus.vout  = !empty;
    assign bus.dout  = empty ? '0 : mem[rd_ptr];
    assign bus.level = count;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_fir_out_buf.sv
// Self-checking bench for fir_out_buf: directed vector table, corner sequences, randomized run vs a queue model.
module tb_fir_out_buf;
    localparam int W  = 11;
    localparam int D  = 8;
    localparam int LW = $clog2(D) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    fir_out_buf_if #(.WIDTH(W), .DEPTH(D)) bus ();

    fir_out_buf #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          vin;
        logic [W-1:0]  din;
        logic          ready;
        logic          vout;
        logic [W-1:0]  dout;
        logic [LW-1:0] level;
        logic          ovf_pulse;
        logic          ovf_sticky;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the buffer contents as a plain queue, head at index 0.
    logic [W-1:0] exp_q[$];
    logic         exp_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sel_ovf(input logic pulse, input logic sticky);
`ifdef FIR_OUT_BUF_OVF_STICKY_EN
        return sticky;
`else
        return pulse;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        exp_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic r);
        logic ev;
        ev = 1'b0;
        if (exp_q.size() != 0 && r) void'(exp_q.pop_front());
        if (v) begin
            if (exp_q.size() < D) exp_q.push_back(d);
            else ev = 1'b1;
        end
        exp_ovf = sel_ovf(ev, exp_ovf | ev);
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] hd;
        hd = (exp_q.size() != 0) ? exp_q[0] : '0;
        check({tag, ".vout"},  32'(bus.vout),  32'(exp_q.size() != 0));
        check({tag, ".dout"},  32'(bus.dout),  32'(hd));
        check({tag, ".level"}, 32'(bus.level), 32'(exp_q.size()));
        check({tag, ".ovf"},   32'(bus.ovf),   32'(exp_ovf));
    endtask

    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r);
        bus.vin   = v;
        bus.din   = d;
        bus.ready = r;
        model_edge(v, d, r);
        @(posedge clk);
        #1;
    endtask

    // Inputs are held active during reset to show they are ignored.
    task automatic apply_reset();
        bus.vin   = 1'b1;
        bus.din   = 11'h2AA;
        bus.ready = 1'b1;
        rst       = 1'b1;
        model_reset();
        #1;
        check_model("rst_async");
        @(posedge clk);
        #1;
        check_model("rst_hold");
        rst       = 1'b0;
        bus.vin   = 1'b0;
        bus.ready = 1'b0;
    endtask

    task automatic add_vec(input logic v, input logic [W-1:0] d, input logic r,
                           input logic ev, input logic [W-1:0] ed, input int el,
                           input logic op, input logic os);
        vec_t t;
        t.vin = v; t.din = d; t.ready = r;
        t.vout = ev; t.dout = ed; t.level = LW'(el);
        t.ovf_pulse = op; t.ovf_sticky = os;
        vecs.push_back(t);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d;
        logic [W-1:0] drain[$];

        bus.vin = 1'b0; bus.din = '0; bus.ready = 1'b0;

        // Directed table: single push, fill to full, dropped 9th sample, in-order drain.
        add_vec(1, 11'h123, 0, 1, 11'h123, 1, 0, 0);
        add_vec(0, 11'h000, 1, 0, 11'h000, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add_vec(1, W'(i), 0, 1, 11'h001, i, 0, 0);
        add_vec(1, 11'h009, 0, 1, 11'h001, 8, 1, 1);
        for (int k = 1; k <= 8; k++)
            add_vec(0, 11'h000, 1, k < 8, (k < 8) ? W'(k + 1) : W'(0), 8 - k, 0, 1);

        @(negedge clk);
        apply_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].vin, vecs[i].din, vecs[i].ready);
            check($sformatf("vec%0d.vout", i),  32'(bus.vout),  32'(vecs[i].vout));
            check($sformatf("vec%0d.dout", i),  32'(bus.dout),  32'(vecs[i].dout));
            check($sformatf("vec%0d.level", i), 32'(bus.level), 32'(vecs[i].level));
            check($sformatf("vec%0d.ovf", i),   32'(bus.ovf),
                  32'(sel_ovf(vecs[i].ovf_pulse, vecs[i].ovf_sticky)));
        end

        // Full buffer with push and pop on the same edge: no drop, 0x7FF comes out last.
        apply_reset();
        for (int i = 0; i < 8; i++) cycle(1, W'(10 + i), 0);
        cycle(1, 11'h7FF, 1);
        check("fullpp.level", 32'(bus.level), 32'd8);
        check("fullpp.ovf",   32'(bus.ovf),   32'd0);
        check("fullpp.dout",  32'(bus.dout),  32'h00B);
        for (int i = 11; i <= 17; i++) drain.push_back(W'(i));
        drain.push_back(11'h7FF);
        for (int j = 1; j <= 8; j++) begin
            cycle(0, '0, 1);
            check($sformatf("fullpp.drain%0d.dout", j), 32'(bus.dout),
                  (j < 8) ? 32'(drain[j]) : 32'd0);
            check($sformatf("fullpp.drain%0d.level", j), 32'(bus.level), 32'(8 - j));
        end

        // Streaming ramp -5..+5 with the consumer always ready.
        apply_reset();
        for (int i = -5; i <= 5; i++) begin
            d = W'(i);
            cycle(1, d, 1);
            check($sformatf("ramp%0d.level", i), 32'(bus.level), 32'd1);
            check($sformatf("ramp%0d.dout", i),  32'(bus.dout),  32'(d));
            check($sformatf("ramp%0d.ovf", i),   32'(bus.ovf),   32'd0);
        end
        cycle(0, '0, 1);
        check("ramp.end.level", 32'(bus.level), 32'd0);

        // Overflow indication held or pulsed over the following cycles.
        apply_reset();
        for (int i = 1; i <= 8; i++) cycle(1, W'(i), 0);
        cycle(1, 11'h03A, 0);
        check("ovf.edge", 32'(bus.ovf), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            cycle(0, '0, 0);
            check($sformatf("ovf.after%0d", i), 32'(bus.ovf), 32'(sel_ovf(1'b0, 1'b1)));
            check($sformatf("ovf.after%0d.dout", i), 32'(bus.dout), 32'h001);
        end

        // Mid-cycle reset with five samples stored.
        apply_reset();
        for (int i = 0; i < 5; i++) cycle(1, W'(11'h100 + i), 0);
        check("midrst.pre.level", 32'(bus.level), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("midrst.vout",  32'(bus.vout),  32'd0);
        check("midrst.level", 32'(bus.level), 32'd0);
        check("midrst.dout",  32'(bus.dout),  32'd0);
        #1 rst = 1'b0;
        model_reset();
        cycle(1, 11'h055, 0);
        check("midrst.post.dout",  32'(bus.dout),  32'h055);
        check("midrst.post.level", 32'(bus.level), 32'd1);

        // Randomized traffic in phases of varying push/pop pressure against the queue model.
        apply_reset();
        for (int ph = 0; ph < 15; ph++) begin
            int pv;
            int pr;
            pv = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            for (int c = 0; c < 200; c++) begin
                cycle($urandom_range(99, 0) < pv, W'($urandom), $urandom_range(99, 0) < pr);
                check_model("rand");
                if ($urandom_range(299, 0) == 0) begin
                    #2 rst = 1'b1;
                    model_reset();
                    #1;
                    check_model("rand.rst");
                    #1 rst = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
